stream_frame_packer: RTL and testbench
======================================

Name: stream_frame_packer

Overview:
- Downstream consumer of the AXI4-Stream mirror produced by the AXI-to-stream bridge.
- Collects 64-bit stream beats into a store-and-forward frame buffer.
- Emits each frame on an output AXI4-Stream: one header beat (magic, sequence number, beat count, split flag) followed by the buffered payload beats, with tlast on the final beat.
- The output feeds the Ethernet TX path.

Parameters:
- MAX_BEATS, 32, maximum payload beats per output frame; legal range 2..256. Buffer depth equals MAX_BEATS.
- MAGIC, 16'hE7A1, constant placed in header bits [63:48].

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  64  input payload beat.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  packer accepts the input beat.
- s_axis_tlast  in  1  last beat of the input packet.
- m_axis_tdata  out  64  header or payload beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts the output beat.
- m_axis_tlast  out  1  last beat of the output frame.
- frame_count  out  16  number of frames fully emitted; wraps at 0xFFFF.

Behaviour:
- Reset (asynchronous, any cycle, including mid-frame):
  - State goes to FILL; write and read pointers = 0; beat counter = 0; seq = 0; frame_count = 0.
  - s_axis_tready = 0 while areset is high, then 1 from the first clock after release.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - Any partially buffered or partially sent frame is discarded. Nothing of it is emitted after reset.
- Beat transfer: a beat moves on a cycle where valid and ready are both high at the rising edge.
- FILL:
  - s_axis_tready = 1 and m_axis_tvalid = 0.
  - Each accepted beat is written to buf[wr_ptr]; wr_ptr and the beat counter increment.
  - The frame closes on the accepted beat that has tlast = 1, or on the beat that makes count == MAX_BEATS, whichever comes first.
  - On close: latch the count (1..MAX_BEATS) and set split = 1 if the closing beat had tlast = 0, else split = 0. Go to HDR.
  - An input packet longer than MAX_BEATS becomes several frames. All but the last have split = 1.
  - A zero-length frame cannot occur.
- HDR:
  - s_axis_tready = 0.
  - m_axis_tvalid = 1 starting the cycle after the closing beat was accepted (1-cycle latency).
  - m_axis_tdata = {MAGIC, seq[15:0], count[15:0], 15'b0, split}; m_axis_tlast = 0.
  - On transfer go to PAYLOAD with rd_ptr = 0.
- PAYLOAD:
  - m_axis_tdata = buf[rd_ptr].
  - m_axis_tlast = 1 only when rd_ptr == count-1.
  - rd_ptr increments on each transfer.
  - On the transfer with tlast: seq and frame_count each increment, wrapping 0xFFFF -> 0. Pointers and counter clear, go to FILL. s_axis_tready = 1 on the following cycle.
- Output stability: while m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata and m_axis_tlast hold unchanged. m_axis_tvalid never drops before the transfer.
- m_axis_tvalid does not depend combinationally on m_axis_tready. s_axis_tready depends only on state.
- Buffer: single-port-write / single-port-read RAM, depth MAX_BEATS, addressed by clog2(MAX_BEATS)-bit pointers.
  - Payload reads must present data in the same cycle the state is PAYLOAD. Prefetch or use registered read with a lookahead so that no bubble appears between payload beats when m_axis_tready stays high.
- Throughput with m_axis_tready held at 1: a frame of N beats takes N cycles to fill, plus 1 cycle of close latency, plus N+1 output cycles.

Test Plan:
- Reset release, then a 3-beat packet with data 0x11, 0x22, 0x33 (last on 0x33), m_axis_tready = 1 -> output 0xE7A1_0000_0003_0000, 0x11, 0x22, 0x33; tlast only on 0x33; frame_count = 1; header appears 1 cycle after 0x33 is accepted.
- 70-beat packet, MAX_BEATS = 32:
  - Frames with counts 32/32/6.
  - split = 1, 1, 0.
  - seq = 0, 1, 2.
  - Payload order is preserved across frames.
  - s_axis_tready is low during each drain.
- Output backpressure: m_axis_tready toggles 1,0,0,1 on a 4-beat frame -> tdata and tlast held during the low cycles; no beat duplicated or lost; no payload bubble while ready is high.
- Sequence wrap: force 65536 single-beat frames (or preload seq = 0xFFFF) -> header seq goes 0xFFFF then 0x0000; frame_count wraps to 0.
- areset asserted mid-PAYLOAD (after beat 2 of 5) -> m_axis_tvalid drops immediately; after release, a new 1-beat packet gives header seq = 0 with count 1, and no remnant of the old frame appears.
- Input valid gaps: 4-beat packet with s_axis_tvalid low on alternate cycles -> header count = 4; output identical to the gap-free case.

Source files
------------

// File: rtl/stream_frame_packer.sv
// Store-and-forward packer: buffers up to MAX_BEATS input beats, then emits a
// header beat (magic, seq, count, split) followed by the buffered payload.
module stream_frame_packer #(
    parameter int          MAX_BEATS = 32,
    parameter logic [15:0] MAGIC     = 16'hE7A1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_count
);
    localparam int          AW      = $clog2(MAX_BEATS);
    localparam int          LANES   = 4;
    localparam logic [15:0] MAX_CNT = 16'(MAX_BEATS);

    typedef enum logic [1:0] {FILL, HDR, PAYLOAD} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [15:0]   cnt_reg, cnt_next;
    logic [15:0]   len_reg, len_next;
    logic          split_reg, split_next;
    logic [15:0]   seq_reg, seq_next;
    logic [15:0]   frame_count_reg, frame_count_next;
    logic          s_ready_reg;

    logic          in_fire;
    logic          out_fire;
    logic          last_pay;
    logic          close;
    logic [63:0]   rd_data;

    assign in_fire  = s_axis_tvalid && s_axis_tready;
    assign out_fire = m_axis_tvalid && m_axis_tready;
    assign last_pay = (state_reg == PAYLOAD) && (16'(rd_ptr_reg) == len_reg - 16'd1);
    assign close    = in_fire && (s_axis_tlast || (cnt_reg + 16'd1 == MAX_CNT));

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        cnt_next         = cnt_reg;
        len_next         = len_reg;
        split_next       = split_reg;
        seq_next         = seq_reg;
        frame_count_next = frame_count_reg;
        case (state_reg)
            FILL: begin
                if (in_fire) begin
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    cnt_next    = cnt_reg + 16'd1;
                    if (close) begin
                        len_next   = cnt_reg + 16'd1;
                        split_next = !s_axis_tlast;
                        state_next = HDR;
                    end
                end
            end
            HDR: begin
                rd_ptr_next = '0;
                if (out_fire) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (out_fire) begin
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                    if (last_pay) begin
                        state_next       = FILL;
                        rd_ptr_next      = '0;
                        wr_ptr_next      = '0;
                        cnt_next         = '0;
                        seq_next         = seq_reg + 16'd1;
                        frame_count_next = frame_count_reg + 16'd1;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg       <= FILL;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            cnt_reg         <= '0;
            len_reg         <= '0;
            split_reg       <= 1'b0;
            seq_reg         <= '0;
            frame_count_reg <= '0;
            s_ready_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            cnt_reg         <= cnt_next;
            len_reg         <= len_next;
            split_reg       <= split_next;
            seq_reg         <= seq_next;
            frame_count_reg <= frame_count_next;
            // Registered so that it stays low for the first cycle after reset release.
            s_ready_reg     <= (state_next == FILL);
        end
    end

    // Read address follows rd_ptr_next so the registered read already holds
    // buf[rd_ptr] whenever PAYLOAD is presenting, with no bubble between beats.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [15:0] mem [MAX_BEATS];
            logic [15:0] rd_lane_reg;
            always_ff @(posedge aclk) begin
                if (in_fire) mem[wr_ptr_reg] <= s_axis_tdata[gi*16 +: 16];
                rd_lane_reg <= mem[rd_ptr_next];
            end
            assign rd_data[gi*16 +: 16] = rd_lane_reg;
        end
    endgenerate

    always_comb begin
        m_axis_tdata = '0;
        case (state_reg)
            HDR:     m_axis_tdata = {MAGIC, seq_reg, len_reg, 15'd0, split_reg};
            PAYLOAD: m_axis_tdata = rd_data;
            default: m_axis_tdata = '0;
        endcase
    end

    assign s_axis_tready = s_ready_reg;
    assign m_axis_tvalid = (state_reg != FILL);
    assign m_axis_tlast  = last_pay;
    assign frame_count   = frame_count_reg;
endmodule

// File: tb/tb_stream_frame_packer.sv
// Randomized bench for stream_frame_packer: a queue-based frame model predicts
// every output beat, handshake level and frame count cycle by cycle.
module tb_stream_frame_packer;
    localparam int          MAX_BEATS = 32;
    localparam logic [15:0] MAGIC     = 16'hE7A1;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [15:0] frame_count;

    stream_frame_packer #(.MAX_BEATS(MAX_BEATS), .MAGIC(MAGIC)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .frame_count(frame_count)
    );

    always #5 aclk = ~aclk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: input beats to drive, the frame being collected, and the
    // expected output stream as {is_hdr, tlast, tdata}.
    logic [64:0] in_q[$];
    logic [63:0] cur_q[$];
    logic [65:0] exp_q[$];
    bit          rdy_pat[$];
    logic [15:0] m_seq = '0;
    logic [15:0] m_fc = '0;
    int          stall_pct = 0;
    int          gap_pct = 0;
    bit          gap_alt = 1'b0;
    bit          gap_phase = 1'b0;
    bit          in_hold = 1'b0;
    bit          held_valid = 1'b0;
    logic [63:0] held_data = '0;
    logic        held_last = 1'b0;
    logic [63:0] last_hdr = '0;
    int          pay_seen = 0;

    task automatic model_accept(logic [63:0] data, logic last);
        cur_q.push_back(data);
        if (last || cur_q.size() == MAX_BEATS) begin
            exp_q.push_back({1'b1, 1'b0, MAGIC, m_seq, 16'(cur_q.size()), 15'd0, !last});
            foreach (cur_q[i])
                exp_q.push_back({1'b0, 1'(i == cur_q.size() - 1), cur_q[i]});
            m_seq = m_seq + 16'd1;
            cur_q.delete();
        end
    endtask

    task automatic tick();
        logic [65:0] e;
        bit go;
        @(negedge aclk);
        check_eq("frame_count", 64'(frame_count), 64'(m_fc));
        check_eq("s_ready", 64'(s_axis_tready), 64'(exp_q.size() == 0));
        check_eq("m_valid", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
        // drive this cycle's inputs; an offered beat is held until accepted
        if (!in_hold) begin
            go = gap_alt ? gap_phase : ($urandom_range(99) >= gap_pct);
            if (in_q.size() != 0 && go) begin
                {s_axis_tlast, s_axis_tdata} = in_q.pop_front();
                s_axis_tvalid = 1'b1;
                in_hold = 1'b1;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                s_axis_tdata  = {$urandom, $urandom};
            end
        end
        gap_phase = !gap_phase;
        if (rdy_pat.size() != 0) m_axis_tready = rdy_pat.pop_front();
        else m_axis_tready = ($urandom_range(99) >= stall_pct);
        // handshakes that complete on the coming rising edge
        if (s_axis_tvalid && s_axis_tready) begin
            model_accept(s_axis_tdata, s_axis_tlast);
            in_hold = 1'b0;
        end
        if (m_axis_tvalid) begin
            if (held_valid) begin
                check_eq("hold_data", m_axis_tdata, held_data);
                check_eq("hold_last", 64'(m_axis_tlast), 64'(held_last));
            end
            if (m_axis_tready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("tdata", m_axis_tdata, e[63:0]);
                check_eq("tlast", 64'(m_axis_tlast), 64'(e[64]));
                if (e[65]) begin
                    last_hdr = m_axis_tdata;
                    pay_seen = 0;
                    $display("frame seq=%04h beats=%0d split=%0b", e[47:32], e[31:16], e[0]);
                end else begin
                    pay_seen++;
                end
                if (e[64]) m_fc = m_fc + 16'd1;
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_data  = m_axis_tdata;
                held_last  = m_axis_tlast;
            end
        end else begin
            held_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        check_eq("rst_valid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check_eq("rst_tdata", m_axis_tdata, 64'd0);
        check_eq("rst_s_ready", 64'(s_axis_tready), 64'd0);
        check_eq("rst_frame_count", 64'(frame_count), 64'd0);
        in_q.delete(); cur_q.delete(); exp_q.delete(); rdy_pat.delete();
        m_seq = '0; m_fc = '0; in_hold = 1'b0; held_valid = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        $display("reset applied");
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic push_packet(int len);
        for (int i = 0; i < len; i++)
            in_q.push_back({1'(i == len - 1), $urandom, $urandom});
    endtask

    task automatic run_drain(int budget);
        int n = 0;
        while ((in_q.size() != 0 || in_hold || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drained", 64'(in_q.size() + exp_q.size() + cur_q.size() + int'(in_hold)), 64'd0);
    endtask

    initial begin
        int n;
        do_reset();

        // 3-beat packet, no backpressure
        in_q.push_back({1'b0, 64'h11});
        in_q.push_back({1'b0, 64'h22});
        in_q.push_back({1'b1, 64'h33});
        run_drain(100);
        check_eq("hdr_3beat", last_hdr, 64'hE7A1_0000_0003_0000);
        tick();
        check_eq("fc_3beat", 64'(frame_count), 64'd1);

        // 70-beat packet splits into 32/32/6
        push_packet(70);
        run_drain(400);
        check_eq("hdr_70_last", last_hdr, 64'hE7A1_0003_0006_0000);

        // output backpressure 1,0,0,1 on a 4-beat frame (4 fill cycles first)
        push_packet(4);
        rdy_pat = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 1};
        run_drain(100);
        check_eq("hdr_bp", last_hdr, 64'hE7A1_0004_0004_0000);

        // input gaps on alternate cycles
        gap_alt = 1'b1;
        push_packet(4);
        run_drain(100);
        gap_alt = 1'b0;
        check_eq("hdr_gaps", last_hdr, 64'hE7A1_0005_0004_0000);

        // random lengths, gaps and stalls, packets queued back to back
        gap_pct = 30;
        stall_pct = 30;
        for (int p = 0; p < 6; p++) begin
            push_packet($urandom_range(1, 80));
            push_packet($urandom_range(1, 40));
            run_drain(3000);
        end
        gap_pct = 0;
        stall_pct = 0;

        // sequence and frame_count wrap
        force dut.seq_reg = 16'hFFFF;
        force dut.frame_count_reg = 16'hFFFF;
        m_seq = 16'hFFFF;
        m_fc = 16'hFFFF;
        tick();
        release dut.seq_reg;
        release dut.frame_count_reg;
        push_packet(1);
        run_drain(50);
        check_eq("hdr_wrap_ffff", last_hdr, 64'hE7A1_FFFF_0001_0000);
        push_packet(1);
        run_drain(50);
        check_eq("hdr_wrap_0000", last_hdr, 64'hE7A1_0000_0001_0000);
        tick();
        check_eq("fc_wrap", 64'(frame_count), 64'd1);

        // reset mid-payload after two of five beats
        push_packet(5);
        n = 0;
        while (pay_seen < 2 && n < 100) begin
            tick();
            n++;
        end
        check_eq("pay_reached", 64'(pay_seen), 64'd2);
        do_reset();
        push_packet(1);
        run_drain(50);
        check_eq("hdr_after_rst", last_hdr, 64'hE7A1_0000_0001_0000);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
